ddr3_x16_dram_emu: RTL and testbench
====================================

# ddr3_x16_dram_emu

Synthesizable DRAM-side responder for on-chip loopback testing of the x16 DDR3 PHY. It decodes the PHY's DDR3 command pins, keeps a small burst memory, and captures write bursts. On READ commands it returns BL8 bursts as half-rate beat vectors with DQS and output-enable patterns, ready for the FPGA output serializers. It sits at the pins side of the PHY and replaces the external SDRAM when the PHY read path is tested in hardware.

## Interface
Parameters:
- p_DQ_W, 16: data width per beat.
- p_BANK_W, 3: bank address width.
- p_ADDR_W, 14: address bus width (row width); A10 is the auto-precharge/all-banks bit.
- p_COL_W, 10: column width, taken from in_ddr_addr[p_COL_W-1:0].
- p_MEM_AW, 4: burst memory depth is 2^p_MEM_AW bursts of 8 words.
- p_RL, 3: read latency in i_clk_div cycles, from the READ command to the first data cycle. Must be 2 or more.
- p_WL, 2: write latency in i_clk_div cycles, from the WRITE command to the first write-data cycle. Must be 1 or more.

Ports:
- i_clk_div, in, 1: the only clock. Half the DDR clock rate; 4 beats per cycle.
- i_rst, in, 1: asynchronous reset, active high.
- i_ddr_ncs, i_ddr_nras, i_ddr_ncas, i_ddr_nwe, in, 1 each: command pins, sampled once per cycle.
- in_ddr_bank, in, p_BANK_W: bank address.
- in_ddr_addr, in, p_ADDR_W: row or column address.
- in_wr_dq, in, 4*p_DQ_W: write beats. Beat 0 is in the LSBs.
- i4_wr_dm, in, 4: write mask, one bit per beat. 1 = beat masked.
- on_rd_dq, out, 4*p_DQ_W: read beats. Beat 0 is in the LSBs.
- o4_dqs, out, 4: DQS level per beat, LSB first.
- o_dq_oe, out, 1: DQ drive enable.
- o_dqs_oe, out, 1: DQS drive enable.
- o_err, out, 1: sticky protocol error flag.
- o16_rd_cnt, out, 16: count of accepted READs, wraps.
- o16_wr_cnt, out, 16: count of accepted WRITEs, wraps.

## Operation
- Command decode, when i_ddr_ncs=0, using {nras,ncas,nwe}:
  - 011 = ACT: record the open row for the bank and set the bank's open flag.
  - 101 = READ.
  - 100 = WRITE.
  - 010 = PRE: clear the bank's open flag, or all banks' flags if A10=1.
  - All other codes, and i_ddr_ncs=1, are NOPs.
- Memory index is {in_ddr_addr[p_MEM_AW+2:3]}. The bank is ignored for indexing, so aliasing across banks is intended.
- READ or WRITE to a bank with no open row: set o_err, and execute the command anyway.
- Burst spacing: a READ or WRITE issued less than 2 cycles after the previous accepted READ or WRITE is dropped. It sets o_err and does not increment the counters.
- Write capture:
  - WRITE at cycle T: beats 0-3 are sampled at edge T+p_WL, beats 4-7 at edge T+p_WL+1.
  - The 8-word burst is committed at edge T+p_WL+1.
  - Masked beats leave the stored word unchanged.
- Read data for a READ at T reflects all commits at edges up to and including T+p_RL-2. Later commits are not visible.
- Memory contents are not reset. A read of a location never written returns undefined data.
- o_err is cleared only by i_rst.

## Timing
- Reset: all outputs are 0 asynchronously.
  - Read/write pipelines, open-row flags, spacing tracker and counters are cleared.
  - A burst in flight is abandoned, and o_dq_oe/o_dqs_oe fall immediately.
- Cycle N below means the registered outputs updated at edge N. For a READ sampled at edge T:
  - Cycle T+p_RL-1, preamble: o_dqs_oe=1, o4_dqs=4'b0000, o_dq_oe=0.
  - Cycle T+p_RL: o_dq_oe=1, on_rd_dq = words 0-3, o4_dqs=4'b1010 (beat0 low, beat1 high, …).
  - Cycle T+p_RL+1: words 4-7, o4_dqs=4'b1010.
  - Cycle T+p_RL+2, postamble: o_dqs_oe=1, o4_dqs=4'b0000, o_dq_oe=0.
  - Cycle T+p_RL+3: all enables 0, on_rd_dq=0.
- Back-to-back READs at T and T+2:
  - The four data cycles are contiguous.
  - Data takes priority over a preamble or postamble in the same cycle, so there is one preamble and one postamble.
  - o_dqs_oe stays continuously high.
- Counters increment at the edge the command is accepted.

## Test plan
- Reset check: assert i_rst mid-simulation -> every output reads 0 in the same cycle; o_err=0; counters=0.
- Write then read:
  - ACT bank4 row13.
  - WRITE bank4 col8 with beats 0x0011,0x2233,…,0xeeff.
  - READ bank4 col8 at T (p_RL=3).
  - Required: preamble at T+2; words 0x0011..0x6677 at T+3; 0x8899..0xeeff at T+4; postamble at T+5; o16_rd_cnt=1; o16_wr_cnt=1.
- Back-to-back reads:
  - READ col8 at T, READ col16 at T+2.
  - Required: data cycles T+3..T+6 contiguous with the correct words; o_dqs_oe high from T+2 to T+7.
- Masked write: write 0x0102…, then rewrite with i4_wr_dm=4'b0100 in the first beat cycle -> readback shows only beat 2 retaining 0x0506.
- Protocol errors:
  - READ to an unopened bank -> o_err=1 and data still returned.
  - READ at T+1 after READ at T -> second READ dropped; o16_rd_cnt increments once.
- Reset mid-burst: assert i_rst during the first data cycle -> o_dq_oe=0 immediately; no residual burst after release.

Source files
------------

// File: rtl/ddr3_x16_dram_emu.sv
// DRAM-side responder for x16 DDR3 PHY loopback: decodes command pins, stores
// BL8 write bursts and plays them back as half-rate beat vectors with DQS/OE.
module ddr3_x16_dram_emu #(
  parameter int p_DQ_W   = 16,
  parameter int p_BANK_W = 3,
  parameter int p_ADDR_W = 14,
  parameter int p_COL_W  = 10,
  parameter int p_MEM_AW = 4,
  parameter int p_RL     = 3,
  parameter int p_WL     = 2
) (
  input  logic                  i_clk_div,
  input  logic                  i_rst,
  input  logic                  i_ddr_ncs,
  input  logic                  i_ddr_nras,
  input  logic                  i_ddr_ncas,
  input  logic                  i_ddr_nwe,
  input  logic [p_BANK_W-1:0]   in_ddr_bank,
  input  logic [p_ADDR_W-1:0]   in_ddr_addr,
  input  logic [4*p_DQ_W-1:0]   in_wr_dq,
  input  logic [3:0]            i4_wr_dm,
  output logic [4*p_DQ_W-1:0]   on_rd_dq,
  output logic [3:0]            o4_dqs,
  output logic                  o_dq_oe,
  output logic                  o_dqs_oe,
  output logic                  o_err,
  output logic [15:0]           o16_rd_cnt,
  output logic [15:0]           o16_wr_cnt
);

  localparam int c_BEAT_W    = 4 * p_DQ_W;
  localparam int c_BURST_W   = 8 * p_DQ_W;
  localparam int c_NBANK     = 2 ** p_BANK_W;
  localparam int c_MEM_WORDS = (2 ** p_MEM_AW) * 8;
  localparam int c_A10       = 10;
  localparam int c_GAP       = 2;

  logic                  cmd_sel;
  logic [2:0]            cmd_code;
  logic                  cmd_act, cmd_rd, cmd_wr, cmd_pre;
  logic [p_COL_W-1:0]    col_addr;
  logic [p_MEM_AW-1:0]   cmd_idx;
  logic                  rw_req, rw_drop, rd_acc, wr_acc, bank_open;

  logic [c_NBANK-1:0]    open_q, open_d;
  logic [p_ADDR_W-1:0]   open_row_q [c_NBANK];
  logic [p_ADDR_W-1:0]   open_row_d [c_NBANK];
  logic [1:0]            gap_cnt_q, gap_cnt_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;

  logic [p_RL+1:0]       rd_pipe_q, rd_pipe_d;
  logic [p_MEM_AW-1:0]   rd_idx_q [p_RL-1];
  logic [p_MEM_AW-1:0]   rd_idx_d [p_RL-1];
  logic [p_WL:0]         wr_pipe_q, wr_pipe_d;
  logic [p_MEM_AW-1:0]   wr_idx_q [p_WL+1];
  logic [p_MEM_AW-1:0]   wr_idx_d [p_WL+1];
  logic [c_BEAT_W-1:0]   wr_lo_q, wr_lo_d;
  logic [3:0]            wr_dm_lo_q, wr_dm_lo_d;
  logic [c_BURST_W-1:0]  rd_buf_q, rd_buf_d;

  logic [c_BEAT_W-1:0]   rd_dq_q, rd_dq_d;
  logic [3:0]            dqs_q, dqs_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  dqs_oe_q, dqs_oe_d;

  logic [p_DQ_W-1:0]     mem_q [c_MEM_WORDS];
  logic [7:0]            mem_we;
  logic [c_BURST_W-1:0]  mem_wdata;
  logic [p_MEM_AW-1:0]   mem_widx;
  logic                  rd_cap;
  logic [p_MEM_AW-1:0]   rd_cap_idx;
  logic [c_BURST_W-1:0]  rd_burst;
  logic                  beat_lo, beat_hi, amble;

  // Row address is kept for visibility only; nothing downstream depends on it.
  logic unused_ok;
  assign unused_ok = ^{col_addr, open_row_q[in_ddr_bank]};

  always_comb begin
    cmd_sel  = ~i_ddr_ncs;
    cmd_code = {i_ddr_nras, i_ddr_ncas, i_ddr_nwe};
    cmd_act  = cmd_sel && (cmd_code == 3'b011);
    cmd_rd   = cmd_sel && (cmd_code == 3'b101);
    cmd_wr   = cmd_sel && (cmd_code == 3'b100);
    cmd_pre  = cmd_sel && (cmd_code == 3'b010);
    col_addr = in_ddr_addr[p_COL_W-1:0];
    cmd_idx  = col_addr[p_MEM_AW+2:3];
  end

  always_comb begin
    rw_req    = cmd_rd | cmd_wr;
    rw_drop   = rw_req && (gap_cnt_q != 2'd0);
    rd_acc    = cmd_rd && !rw_drop;
    wr_acc    = cmd_wr && !rw_drop;
    bank_open = open_q[in_ddr_bank];

    open_d     = open_q;
    open_row_d = open_row_q;
    if (cmd_act) begin
      open_d[in_ddr_bank]     = 1'b1;
      open_row_d[in_ddr_bank] = in_ddr_addr;
    end
    if (cmd_pre) begin
      if (in_ddr_addr[c_A10]) open_d = '0;
      else                    open_d[in_ddr_bank] = 1'b0;
    end

    // Down-counter: nonzero means the previous accepted burst is too recent.
    if (rd_acc || wr_acc)        gap_cnt_d = 2'(c_GAP - 1);
    else if (gap_cnt_q != 2'd0)  gap_cnt_d = gap_cnt_q - 2'd1;
    else                         gap_cnt_d = 2'd0;

    err_d    = err_q | rw_drop | ((rd_acc | wr_acc) & ~bank_open);
    rd_cnt_d = rd_cnt_q + 16'(rd_acc);
    wr_cnt_d = wr_cnt_q + 16'(wr_acc);
  end

  always_comb begin
    rd_pipe_d   = {rd_pipe_q[p_RL:0], rd_acc};
    rd_idx_d[0] = cmd_idx;
    for (int k = 1; k < p_RL - 1; k++) rd_idx_d[k] = rd_idx_q[k-1];

    wr_pipe_d   = {wr_pipe_q[p_WL-1:0], wr_acc};
    wr_idx_d[0] = cmd_idx;
    for (int k = 1; k <= p_WL; k++) wr_idx_d[k] = wr_idx_q[k-1];

    wr_lo_d    = wr_pipe_q[p_WL-1] ? in_wr_dq : wr_lo_q;
    wr_dm_lo_d = wr_pipe_q[p_WL-1] ? i4_wr_dm : wr_dm_lo_q;

    mem_widx  = wr_idx_q[p_WL];
    mem_wdata = {in_wr_dq, wr_lo_q};
    mem_we    = wr_pipe_q[p_WL] ? ~{i4_wr_dm, wr_dm_lo_q} : 8'h00;
  end

  // Snapshot is taken one cycle before the first data cycle, so it sees every
  // commit up to two cycles before that.
  always_comb begin
    rd_cap     = rd_pipe_q[p_RL-2];
    rd_cap_idx = rd_idx_q[p_RL-2];
    rd_burst   = '0;
    for (int w = 0; w < 8; w++)
      rd_burst[w*p_DQ_W +: p_DQ_W] = mem_q[{rd_cap_idx, 3'(w)}];
    rd_buf_d = rd_cap ? rd_burst : rd_buf_q;
  end

  // Data cycles win over a coincident preamble/postamble of a neighbouring burst.
  always_comb begin
    beat_lo  = rd_pipe_q[p_RL-1];
    beat_hi  = rd_pipe_q[p_RL];
    amble    = rd_pipe_q[p_RL-2] | rd_pipe_q[p_RL+1];
    rd_dq_d  = '0;
    dqs_d    = 4'b0000;
    dq_oe_d  = 1'b0;
    dqs_oe_d = 1'b0;
    if (beat_lo) begin
      rd_dq_d  = rd_buf_q[c_BEAT_W-1:0];
      dqs_d    = 4'b1010;
      dq_oe_d  = 1'b1;
      dqs_oe_d = 1'b1;
    end else if (beat_hi) begin
      rd_dq_d  = rd_buf_q[c_BURST_W-1:c_BEAT_W];
      dqs_d    = 4'b1010;
      dq_oe_d  = 1'b1;
      dqs_oe_d = 1'b1;
    end else if (amble) begin
      dqs_oe_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      open_q     <= '0;
      for (int b = 0; b < c_NBANK; b++) open_row_q[b] <= '0;
      gap_cnt_q  <= 2'd0;
      err_q      <= 1'b0;
      rd_cnt_q   <= 16'd0;
      wr_cnt_q   <= 16'd0;
      rd_pipe_q  <= '0;
      for (int k = 0; k < p_RL - 1; k++) rd_idx_q[k] <= '0;
      wr_pipe_q  <= '0;
      for (int k = 0; k <= p_WL; k++) wr_idx_q[k] <= '0;
      wr_lo_q    <= '0;
      wr_dm_lo_q <= 4'b0000;
      rd_buf_q   <= '0;
      rd_dq_q    <= '0;
      dqs_q      <= 4'b0000;
      dq_oe_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
    end else begin
      open_q     <= open_d;
      open_row_q <= open_row_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_idx_q   <= rd_idx_d;
      wr_pipe_q  <= wr_pipe_d;
      wr_idx_q   <= wr_idx_d;
      wr_lo_q    <= wr_lo_d;
      wr_dm_lo_q <= wr_dm_lo_d;
      rd_buf_q   <= rd_buf_d;
      rd_dq_q    <= rd_dq_d;
      dqs_q      <= dqs_d;
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
    end
  end

  // Burst storage behaves like a RAM: no reset, per-word enables.
  always_ff @(posedge i_clk_div) begin
    for (int w = 0; w < 8; w++)
      if (mem_we[w]) mem_q[{mem_widx, 3'(w)}] <= mem_wdata[w*p_DQ_W +: p_DQ_W];
  end

  assign on_rd_dq   = rd_dq_q;
  assign o4_dqs     = dqs_q;
  assign o_dq_oe    = dq_oe_q;
  assign o_dqs_oe   = dqs_oe_q;
  assign o_err      = err_q;
  assign o16_rd_cnt = rd_cnt_q;
  assign o16_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_ddr3_x16_dram_emu.sv
// Scoreboard bench for ddr3_x16_dram_emu: reads push expected beats, the
// negedge monitor pops them when the emulator drives data.
module tb_ddr3_x16_dram_emu;
  localparam int RL = 3;
  localparam int WL = 2;
  localparam int NE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
  logic [2:0]  bank = '0;
  logic [13:0] addr = '0;
  logic [63:0] wr_dq = '0;
  logic [3:0]  wr_dm = '0;
  logic [63:0] rd_dq;
  logic [3:0]  dqs;
  logic        dq_oe, dqs_oe, err;
  logic [15:0] rd_cnt, wr_cnt;

  ddr3_x16_dram_emu dut (
    .i_clk_div  (clk),
    .i_rst      (rst),
    .i_ddr_ncs  (ncs),
    .i_ddr_nras (nras),
    .i_ddr_ncas (ncas),
    .i_ddr_nwe  (nwe),
    .in_ddr_bank(bank),
    .in_ddr_addr(addr),
    .in_wr_dq   (wr_dq),
    .i4_wr_dm   (wr_dm),
    .on_rd_dq   (rd_dq),
    .o4_dqs     (dqs),
    .o_dq_oe    (dq_oe),
    .o_dqs_oe   (dqs_oe),
    .o_err      (err),
    .o16_rd_cnt (rd_cnt),
    .o16_wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct { logic [63:0] data; int due; } beat_t;
  beat_t       sb_q[$];
  beat_t       mon_b;
  bit          exp_data [NE];
  bit          exp_amb  [NE];
  logic [15:0] model_mem [128];
  int          exp_rd = 0, exp_wr = 0;
  int          n_chk = 0, n_err = 0;
  bit          run = 1'b0;
  logic [127:0] burst_a, burst_b, burst_c, burst_d;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] code, input logic [2:0] b, input logic [13:0] a);
    ncs = 1'b0;
    {nras, ncas, nwe} = code;
    bank = b;
    addr = a;
    tick();
    ncs = 1'b1;
    {nras, ncas, nwe} = 3'b111;
  endtask

  task automatic do_write(input logic [2:0] b, input logic [13:0] col,
                          input logic [127:0] burst, input logic [3:0] dm_lo);
    int idx;
    idx = int'(col[6:3]);
    for (int i = 0; i < 8; i++)
      if (!(i < 4 && dm_lo[i])) model_mem[idx*8+i] = burst[i*16 +: 16];
    exp_wr++;
    cmd(3'b100, b, col);
    repeat (WL - 1) tick();
    wr_dq = burst[63:0];
    wr_dm = dm_lo;
    tick();
    wr_dq = burst[127:64];
    wr_dm = 4'b0000;
    tick();
    wr_dq = '0;
  endtask

  task automatic do_read(input logic [2:0] b, input logic [13:0] col, input bit acc);
    int t, idx;
    beat_t lo, hi;
    t   = edge_n + 1;
    idx = int'(col[6:3]);
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        lo.data[i*16 +: 16] = model_mem[idx*8+i];
        hi.data[i*16 +: 16] = model_mem[idx*8+4+i];
      end
      lo.due = t + RL;
      hi.due = t + RL + 1;
      sb_q.push_back(lo);
      sb_q.push_back(hi);
      exp_amb[t+RL-1]  = 1'b1;
      exp_data[t+RL]   = 1'b1;
      exp_data[t+RL+1] = 1'b1;
      exp_amb[t+RL+2]  = 1'b1;
      exp_rd++;
    end
    cmd(3'b101, b, col);
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      if (dq_oe && sb_q.size() != 0) begin
        mon_b = sb_q.pop_front();
        chk("rd_data", rd_dq, mon_b.data);
        chk("rd_edge", 64'(edge_n), 64'(mon_b.due));
        chk("rd_dqs", dqs, 4'b1010);
      end else if (!dq_oe) begin
        chk("idle_dq", rd_dq, 64'd0);
        chk("idle_dqs", dqs, 4'b0000);
      end
      chk("dq_oe", dq_oe, exp_data[edge_n]);
      chk("dqs_oe", dqs_oe, exp_data[edge_n] | exp_amb[edge_n]);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      burst_a[i*16 +: 16] = 16'h0011 + 16'(i * 16'h2222);
      burst_b[i*16 +: 16] = 16'h5a00 + 16'(i * 3);
      burst_c[i*16 +: 16] = {8'(2*i+1), 8'(2*i+2)};
      burst_d[i*16 +: 16] = 16'hf000 + 16'(i);
    end

    tick();
    chk("rst_dq", rd_dq, 64'd0);
    chk("rst_dq_oe", dq_oe, 1'b0);
    chk("rst_dqs_oe", dqs_oe, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_cnt", rd_cnt, 16'd0);
    tick();
    rst = 1'b0;
    run = 1'b1;
    tick();

    // write then read
    cmd(3'b011, 3'd4, 14'd13);
    do_write(3'd4, 14'd8, burst_a, 4'b0000);
    do_read(3'd4, 14'd8, 1'b1);
    repeat (8) tick();
    chk("rd_cnt_1", rd_cnt, 16'(exp_rd));
    chk("wr_cnt_1", wr_cnt, 16'(exp_wr));
    chk("err_clean", err, 1'b0);

    // back-to-back reads two cycles apart
    do_write(3'd4, 14'd16, burst_b, 4'b0000);
    do_read(3'd4, 14'd8, 1'b1);
    tick();
    do_read(3'd4, 14'd16, 1'b1);
    repeat (8) tick();

    // masked rewrite keeps beat 2
    do_write(3'd4, 14'd24, burst_c, 4'b0000);
    do_write(3'd4, 14'd24, burst_d, 4'b0100);
    do_read(3'd4, 14'd24, 1'b1);
    repeat (8) tick();
    chk("err_still_clean", err, 1'b0);
    chk("wr_cnt_2", wr_cnt, 16'(exp_wr));

    // too-close read is dropped
    do_read(3'd4, 14'd16, 1'b1);
    do_read(3'd4, 14'd24, 1'b0);
    repeat (8) tick();
    chk("err_drop", err, 1'b1);
    chk("rd_cnt_drop", rd_cnt, 16'(exp_rd));

    // reset during the first data cycle
    do_read(3'd4, 14'd8, 1'b1);
    repeat (3) tick();
    chk("pre_rst_dq_oe", dq_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dq_oe", dq_oe, 1'b0);
    chk("mid_rst_dqs_oe", dqs_oe, 1'b0);
    chk("mid_rst_dq", rd_dq, 64'd0);
    chk("mid_rst_dqs", dqs, 4'b0000);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_rd_cnt", rd_cnt, 16'd0);
    chk("mid_rst_wr_cnt", wr_cnt, 16'd0);
    sb_q.delete();
    for (int i = 0; i < NE; i++) begin
      exp_data[i] = 1'b0;
      exp_amb[i]  = 1'b0;
    end
    exp_rd = 0;
    exp_wr = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();

    // read to a bank with no open row still returns data
    chk("err_after_rst", err, 1'b0);
    do_read(3'd2, 14'd8, 1'b1);
    repeat (8) tick();
    chk("err_unopened", err, 1'b1);
    chk("rd_cnt_after_rst", rd_cnt, 16'(exp_rd));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
